// File: rtl/key_event.sv
// rtl/key_event.sv - five-key synchronizer, debounce, auto-repeat and prioritized event serializer
module key_event #(
    parameter int DEB_CNT   = 1000000,
    parameter int REP_DELAY = 25000000,
    parameter int REP_RATE  = 5000000
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       ke,
    input  logic       ku,
    input  logic       kd,
    input  logic       kr,
    input  logic       kl,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic [4:0] key_level,
    output logic       evt_drop
);

    localparam int DW   = $clog2(DEB_CNT);
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DC_TERM    = DW'(DEB_CNT - 1);
    localparam logic [RW-1:0] DELAY_TERM = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RATE_TERM  = RW'(REP_RATE - 1);

    // Bit order everywhere: [4]=E [3]=U [2]=D [1]=R [0]=L
    logic [4:0]    raw;
    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    s;
    logic [DW-1:0] dc [5];
    logic [4:0]    differ;
    logic [4:0]    deb_hit;
    logic [4:0]    rise;

    // Auto-repeat state, index 0 = D (bit 2), index 1 = U (bit 3)
    logic [RW-1:0] rc [2];
    logic [1:0]    phase;
    logic [1:0]    held;
    logic [1:0]    rep_fire;

    logic [4:0]    pending;
    logic [4:0]    set_vec;
    logic [4:0]    grant;
    logic [2:0]    code_nxt;

    assign raw = {ke, ku, kd, kr, kl};
    assign s   = ~sync2;

    // Two-stage synchronizer; idle (released) level is 1
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync1 <= 5'h1f;
            sync2 <= 5'h1f;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-key compare of synchronized input against debounced level
    always_comb begin
        differ  = '0;
        deb_hit = '0;
        rise    = '0;
        for (int k = 0; k < 5; k++) begin
            differ[k]  = (s[k] != key_level[k]);
            deb_hit[k] = differ[k] && (dc[k] == DC_TERM);
            rise[k]    = deb_hit[k] && s[k];
        end
    end

    // Stable-time debounce: level only moves after DEB_CNT consecutive differing samples
    always_ff @(posedge clkin) begin
        if (rst) begin
            key_level <= '0;
            for (int k = 0; k < 5; k++) begin
                dc[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (!differ[k]) begin
                    dc[k] <= '0;
                end else if (deb_hit[k]) begin
                    key_level[k] <= s[k];
                    dc[k]        <= '0;
                end else begin
                    dc[k] <= dc[k] + 1'b1;
                end
            end
        end
    end

    // Repeat fires on terminal count; a key falling this edge is already treated as released
    always_comb begin
        held     = '0;
        rep_fire = '0;
        for (int j = 0; j < 2; j++) begin
            held[j]     = key_level[j+2] && !(deb_hit[j+2] && !s[j+2]);
            rep_fire[j] = held[j] && (rc[j] == (phase[j] ? RATE_TERM : DELAY_TERM));
        end
    end

    // Repeat counters: REP_DELAY for the first repeat, REP_RATE afterwards
    always_ff @(posedge clkin) begin
        for (int j = 0; j < 2; j++) begin
            if (rst || !held[j]) begin
                rc[j]    <= '0;
                phase[j] <= 1'b0;
            end else if (rep_fire[j]) begin
                rc[j]    <= '0;
                phase[j] <= 1'b1;
            end else begin
                rc[j] <= rc[j] + 1'b1;
            end
        end
    end

    assign set_vec = rise | {1'b0, rep_fire[1], rep_fire[0], 2'b00};

    // Fixed-priority pick of one pending key: E > U > D > R > L
    always_comb begin
        grant    = '0;
        code_nxt = 3'd0;
        if (pending[4]) begin
            grant    = 5'b10000;
            code_nxt = 3'd1;
        end else if (pending[3]) begin
            grant    = 5'b01000;
            code_nxt = 3'd2;
        end else if (pending[2]) begin
            grant    = 5'b00100;
            code_nxt = 3'd3;
        end else if (pending[1]) begin
            grant    = 5'b00010;
            code_nxt = 3'd4;
        end else if (pending[0]) begin
            grant    = 5'b00001;
            code_nxt = 3'd5;
        end
    end

    // Pending buffer and registered event outputs; a new set beats a same-cycle serve
    always_ff @(posedge clkin) begin
        if (rst) begin
            pending   <= '0;
            evt_valid <= 1'b0;
            evt_code  <= 3'd0;
            evt_drop  <= 1'b0;
        end else begin
            pending   <= (pending & ~grant) | set_vec;
            evt_valid <= |pending;
            evt_code  <= code_nxt;
            evt_drop  <= |(set_vec & pending & ~grant);
        end
    end

endmodule

// File: doc/key_event.md
# key_event

Front-end keypad conditioner for the DDS generator: it takes the five raw active-low push-buttons (ke, ku, kd, kr, kl) and produces a clean, serialized stream of one-cycle key events. The frequency/amplitude control logic downstream consumes this stream and contains no debounce counters of its own. Per-key behaviour:
- 2-FF synchronizer, then stable-time debounce.
- Press-edge detection; auto-repeat on ku/kd.
- Pending-event buffer served in fixed priority.

## Interface
Parameters:
- DEB_CNT, 1000000: cycles a synchronized input must be stable before the debounced level changes (20 ms at 50 MHz); ≥2.
- REP_DELAY, 25000000: cycles a ku/kd key must be held before the first repeat; ≥1.
- REP_RATE, 5000000: cycles between subsequent repeats; ≥1.

Ports:
- clkin  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ke, ku, kd, kr, kl  in  1 each  raw buttons, active low, asynchronous to clkin.
- evt_valid  out  1  one-cycle strobe; an event is presented this cycle.
- evt_code  out  3  event id when evt_valid=1: 1=E, 2=U, 3=D, 4=R, 5=L; 0 otherwise.
- key_level  out  5  debounced pressed levels, active high, bit order {E,U,D,R,L} = [4:0].
- evt_drop  out  1  one-cycle strobe; an event arrived for a key whose pending bit was already set.

## Operation
- Synchronizer: two flops per key, reset to 1 (released). s_k is the second-stage output, inverted to active-high pressed.
- Debounce, per key, using counter dc_k (width clog2(DEB_CNT)):
  - If s_k equals key_level[k]: dc_k := 0.
  - Otherwise dc_k increments.
  - When dc_k = DEB_CNT-1 and s_k still differs: key_level[k] takes s_k on the next edge and dc_k := 0.
  - Any bounce back to the current level before the terminal count clears dc_k.
- Press event: a 0→1 transition of key_level[k] sets pending[k]. Release generates no event.
- Auto-repeat (U and D only), using counter rc_k (width ≥ clog2(max(REP_DELAY, REP_RATE))):
  - While key_level[k]=1, rc_k counts.
  - The first repeat fires when the cycle count since the press edge reaches REP_DELAY; rc_k then reloads.
  - Further repeats fire every REP_RATE cycles while the key is held.
  - Key release clears rc_k and the repeat phase immediately.
  - E, R and L never repeat.
- Pending buffer: one bit per key.
  - Setting a bit that is already set: the bit stays 1 and evt_drop pulses that cycle.
  - Set and serve of the same key in the same cycle: the set wins, the bit stays 1, and no drop is reported.
- Arbiter: each cycle, if any pending bit is set, serve the highest priority E > U > D > R > L.
  - Registered outputs: evt_valid=1 and evt_code=id on the next edge; the served bit is cleared.
  - At most one event per cycle.
  - Lower-priority bits wait and are never lost.
- Reset values (all cleared in the same edge rst is sampled high):
  - key_level=0, dc/rc=0, pending=0, evt_valid=0, evt_code=0, evt_drop=0, sync flops=1.
  - rst asserted mid-debounce or mid-repeat discards all state.
  - A key held through reset is seen as a fresh press once the debounce completes after rst deasserts.

## Timing
- Raw pin falls (press) to key_level[k]=1: 2 sync cycles + DEB_CNT cycles.
- key_level rise to pending set: same edge.
- Pending set to evt_valid: 1 cycle, if no higher-priority bit is pending; otherwise +1 cycle per higher pending key.
- N pending keys drain in exactly N consecutive cycles.
- evt_valid is high for exactly one cycle per event; evt_code returns to 0 when evt_valid=0.
- Repeat events: first at press-edge + REP_DELAY cycles, then every REP_RATE cycles, each followed by the 1-cycle arbiter latency.
- No handshake or backpressure: the consumer must accept an event in the cycle evt_valid=1.

## Test plan
Bench parameters: DEB_CNT=8, REP_DELAY=20, REP_RATE=5.
- Reset: hold rst 3 cycles with ke..kl=1 → all outputs 0; release rst, pins idle 50 cycles → no evt_valid.
- Clean press: ku low at cycle 0, held → key_level[3]=1 at cycle 10; evt_valid=1 with evt_code=2 at cycle 11; repeats at cycles 31, 36, 41 …; release → no further events and no release event.
- Bounce: kr toggles every 3 cycles for 30 cycles, then stays low → exactly one evt_code=4, 8 cycles after stabilization + sync + 1.
- Simultaneous press: ke, kd and kl go low on the same edge → evt_code 1, 3, 5 on three consecutive cycles.
- Coalesce/drop: hold ku with REP_RATE=1 while ke is also pending → evt_drop pulses; no U event is lost beyond one held in pending; the E event comes first.
- Reset mid-debounce: kd low, rst pulsed at cycle 6, kd kept low → no event before cycle 6+1+2+8; then a single evt_code=3.
